// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch queue: default widths, the queue
// entry layout and a small popcount used by lane compaction.
package fetch_pkg;

    localparam int FETCH_XLEN  = 64;
    localparam int FETCH_WIDTH = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pred_target;
        logic                  pred_taken;
    } fetch_entry_t;

    // Lane masks are at most 8 bits wide, so a 4-bit result always suffices.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/fetch_compact.sv
// Lane compaction: keeps valid lanes up to and including the first predicted-taken
// lane, then squeezes the survivors into the low output slots in lane order.
module fetch_compact
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH,
    parameter int XLEN  = FETCH_XLEN,
    localparam int NW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH*XLEN-1:0] lane_instr,
    input  logic [WIDTH*XLEN-1:0] lane_target,
    input  logic [WIDTH-1:0]      lane_valid,
    input  logic [WIDTH-1:0]      lane_taken,
    output logic [WIDTH*XLEN-1:0] pk_instr,
    output logic [WIDTH*XLEN-1:0] pk_target,
    output logic [WIDTH-1:0]      pk_taken,
    output logic [NW-1:0]         n_enq
);

    logic [WIDTH-1:0] accept;
    logic             stop;
    int               pos;
    int               rank [WIDTH];

    always_comb begin
        accept    = '0;
        stop      = 1'b0;
        pos       = 0;
        pk_instr  = '0;
        pk_target = '0;
        pk_taken  = '0;
        // rank[i] is the output slot lane i lands in if it is accepted.
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = lane_valid[i] && !stop;
            if (accept[i] && lane_taken[i]) begin
                stop = 1'b1;
            end
            rank[i] = pos;
            if (accept[i]) begin
                pos = pos + 1;
            end
        end
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i] && rank[i] == j) begin
                    pk_instr[j*XLEN +: XLEN]  = lane_instr[i*XLEN +: XLEN];
                    pk_target[j*XLEN +: XLEN] = lane_target[i*XLEN +: XLEN];
                    pk_taken[j]               = lane_taken[i];
                end
            end
        end
    end

    assign n_enq = NW'(popcount(8'(accept)));

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: compacts up to WIDTH icache lanes per cycle into a circular
// buffer and presents up to WIDTH in-order entries per cycle to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH,
    parameter int XLEN  = FETCH_XLEN,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH*XLEN-1:0] in_instr,
    input  logic [WIDTH-1:0]      in_valid,
    input  logic [WIDTH*XLEN-1:0] in_pred_target,
    input  logic [WIDTH-1:0]      in_pred_taken,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  stall,
    output logic [WIDTH*XLEN-1:0] out_instr,
    output logic [WIDTH*XLEN-1:0] out_target,
    output logic [WIDTH-1:0]      out_taken,
    output logic [WIDTH-1:0]      out_valid,
    output logic [CW-1:0]         count
);

    localparam int NW = $clog2(WIDTH + 1);

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pred_target;
        logic            pred_taken;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [WIDTH*XLEN-1:0] pk_instr;
    logic [WIDTH*XLEN-1:0] pk_target;
    logic [WIDTH-1:0]     pk_taken;
    logic [NW-1:0]        n_enq;
    logic [CW-1:0]        n_enq_eff;
    logic [CW-1:0]        n_deq;
    logic                 enq_fire;

    fetch_compact #(
        .WIDTH (WIDTH),
        .XLEN  (XLEN)
    ) u_compact (
        .lane_instr  (in_instr),
        .lane_target (in_pred_target),
        .lane_valid  (in_valid),
        .lane_taken  (in_pred_taken),
        .pk_instr    (pk_instr),
        .pk_target   (pk_target),
        .pk_taken    (pk_taken),
        .n_enq       (n_enq)
    );

    // Handshake: in_ready high means a whole WIDTH group is absorbed on this edge
    // unless flush is high; when in_ready is low the lanes are dropped, not held,
    // and the icache must re-present them. Dequeue space is not credited same-cycle.
    assign in_ready  = (CW'(DEPTH) - count) >= CW'(WIDTH);
    assign enq_fire  = in_ready && !flush;
    assign n_enq_eff = enq_fire ? CW'(n_enq) : '0;
    assign n_deq     = stall ? '0 : ((count < CW'(WIDTH)) ? count : CW'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq_eff);
            count <= count + n_enq_eff - n_deq;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (NW'(i) < n_enq) begin
                    mem[tail + PW'(i)] <= '{instr:       pk_instr[i*XLEN +: XLEN],
                                            pred_target: pk_target[i*XLEN +: XLEN],
                                            pred_taken:  pk_taken[i]};
                end
            end
        end
    end

    always_comb begin
        out_instr  = '0;
        out_target = '0;
        out_taken  = '0;
        out_valid  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_instr[i*XLEN +: XLEN]  = mem[head + PW'(i)].instr;
            out_target[i*XLEN +: XLEN] = mem[head + PW'(i)].pred_target;
            out_taken[i]               = mem[head + PW'(i)].pred_taken;
            out_valid[i]               = (count > CW'(i)) && !flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (n_deq <= count);
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the fixed 4-lane fetch register stage.
- Accepts up to WIDTH instruction lanes per cycle from the icache, each with predictor info.
- Drops invalid lanes, and lanes younger than a predicted-taken branch, then packs the survivors into a circular buffer.
- Presents up to WIDTH in-order entries per cycle to decode, honouring stall and flush.

Parameters:
- WIDTH, 4, fetch/dispatch lanes per cycle (1..8).
- XLEN, 64, instruction and target width in bits.
- DEPTH, 16, queue entries; power of two, >= 2*WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_instr  in  WIDTH*XLEN  icache instructions; lane i = bits [i*XLEN +: XLEN].
- in_valid  in  WIDTH  per-lane icache valid.
- in_pred_target  in  WIDTH*XLEN  per-lane predicted branch target.
- in_pred_taken  in  WIDTH  per-lane predicted-taken flag.
- in_ready  out  1  queue can absorb a full WIDTH group this cycle.
- flush  in  1  redirect; discard all queued and incoming entries.
- stall  in  1  decode not consuming this cycle.
- out_instr  out  WIDTH*XLEN  head entries, oldest in lane 0.
- out_target  out  WIDTH*XLEN  predicted target per output lane.
- out_taken  out  WIDTH  predicted-taken per output lane.
- out_valid  out  WIDTH  output lane holds a live entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async on rst high):
  - head = tail = count = 0; out_valid = 0; in_ready = 1.
  - Storage array is not reset; its contents are don't-care while invalid.
- in_ready = (DEPTH - count) >= WIDTH, combinational from registered count.
  - Conservative: same-cycle dequeue space is not credited.
- Enqueue occurs when in_ready && !flush.
- Compaction:
  - Let k = lowest valid lane with in_pred_taken = 1.
  - Accepted lanes = valid lanes with index <= k (all valid lanes if no such k).
  - n_enq = popcount(accepted).
  - Accepted lanes are written in ascending lane order to tail, tail+1, … (mod DEPTH); holes are squeezed out.
- When in_ready = 0, input lanes are ignored, not held; the icache side must re-present them.
- Output is combinational from storage:
  - out lane i = entry at head+i (mod DEPTH).
  - out_valid[i] = (count > i) && !flush.
- Dequeue: n_deq = stall ? 0 : min(count, WIDTH). Decode consumes all valid lanes whenever stall = 0.
- Counters:
  - count_next = count + n_enq - n_deq.
  - head += n_deq, tail += n_enq.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Latency: an entry enqueued in cycle N appears on out no earlier than cycle N+1.
  - No same-cycle bypass.
- Flush (synchronous) has priority over enqueue, dequeue and stall.
  - Next cycle: head = tail = count = 0.
  - During the flush cycle, out_valid = 0 and in_ready is unaffected, but nothing is written.
- Boundary cases:
  - Empty: out_valid = 0, n_deq = 0.
  - Full: in_ready = 0, count holds or drops by n_deq.
  - Wrap: a group straddling DEPTH-1 to 0 is written and read correctly.
  - Stall with empty queue: no effect.
  - Simultaneous enqueue + dequeue at count = DEPTH-WIDTH: legal; count stays <= DEPTH.
  - rst asserted mid-operation: immediate clear regardless of flush/stall.
- Invariant: count never exceeds DEPTH. Assert count <= DEPTH and n_deq <= count.

Decomposition:
- Package fetch_pkg:
  - XLEN and FETCH_WIDTH defaults.
  - fetch_entry_t struct {instr[XLEN], pred_target[XLEN], pred_taken}.
  - Helper function popcount.
- One sub-module, fetch_compact (purely combinational):
  - Inputs: lane entries, valid, taken.
  - Outputs: packed entry array plus n_enq.
  - Implements valid filtering and taken truncation.
- fetch_queue owns pointers, count, storage and output muxing.

Test Plan:
- Reset, then present in_valid=4'b1111 with instr 0x10..0x13 and taken=0, stall=0.
  - Next cycle: out_valid=4'b1111, out_instr lanes = 0x10..0x13, count=4 then 0.
- in_valid=4'b1010 with instr A/B on lanes 1/3.
  - Next cycle: out lane0=A, lane1=B, out_valid=4'b0011.
- in_valid=4'b1111, in_pred_taken=4'b0010, lane1 target 0x8000.
  - Only lanes 0,1 queued; out_taken=2'b10 on lanes 0,1; out_target lane1=0x8000; count=2.
- stall=1 with 4 full groups.
  - count=16, in_ready=0; a 5th group is ignored; releasing stall drains 4/cycle in FIFO order across pointer wrap.
- Queue holding 7 entries, flush=1 while new valid input is presented.
  - out_valid=0 that cycle; count=0 next cycle; no input entries retained.
- Assert rst mid-drain at count=9.
  - Immediately count=0, out_valid=0, in_ready=1; normal operation on deassert.
